// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared state encoding and byte-lane constants for the DRAM word master
package dram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

  // Lane index = transfer order; lane 0 is the most significant byte of the word.
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

endpackage

// File: rtl/word_byte_serdes.sv
// rtl/word_byte_serdes.sv - big-endian byte select for writes, shift assembly for reads
module word_byte_serdes
  import dram_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_load,
  input  logic [WORD_BYTES*DATA_WIDTH-1:0] i_wdata,
  input  logic [1:0]                       i_cnt,
  input  logic                             i_shift,
  input  logic [DATA_WIDTH-1:0]            i_rdata,
  output logic [DATA_WIDTH-1:0]            o_byte,
  output logic [WORD_BYTES*DATA_WIDTH-1:0] o_word
);

  localparam int WW = WORD_BYTES * DATA_WIDTH;

  logic [WW-1:0] r_wdata;
  logic [WW-1:0] r_asm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdata <= '0;
      r_asm   <= '0;
    end else if (i_load) begin
      r_wdata <= i_wdata;
      r_asm   <= '0;
    end else if (i_shift) begin
      // First byte read ends up in the top lane after four shifts.
      r_asm <= {r_asm[WW-DATA_WIDTH-1:0], i_rdata};
    end
  end

  always_comb begin
    o_byte = '0;
    case (i_cnt)
      LANE_B0: o_byte = r_wdata[3*DATA_WIDTH +: DATA_WIDTH];
      LANE_B1: o_byte = r_wdata[2*DATA_WIDTH +: DATA_WIDTH];
      LANE_B2: o_byte = r_wdata[1*DATA_WIDTH +: DATA_WIDTH];
      LANE_B3: o_byte = r_wdata[0 +: DATA_WIDTH];
      default: o_byte = '0;
    endcase
  end

  assign o_word = r_asm;

endmodule

// File: rtl/dram_word_master.sv
// rtl/dram_word_master.sv - serialises 32-bit word requests into four byte-wide DRAM accesses
module dram_word_master
  import dram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [WORD_BYTES*DATA_WIDTH-1:0] req_wdata,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [WORD_BYTES*DATA_WIDTH-1:0] resp_rdata,
  output logic                             resp_err,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic                             mem_we,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  state_t                          r_state;
  state_t                          w_next;
  logic                            r_we;
  logic [ADDR_WIDTH-1:0]           r_base;
  logic [1:0]                      r_cnt;
  logic                            r_err;
  logic                            w_accept;
  logic                            w_xfer;
  logic                            w_misaligned;
  logic [DATA_WIDTH-1:0]           w_byte;
  logic [WORD_BYTES*DATA_WIDTH-1:0] w_word;

  assign w_misaligned = (req_addr[1:0] != 2'b00);

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    w_accept   = 1'b0;
    w_xfer     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = w_misaligned ? ST_RESP : ST_XFER;
        end
      end
      ST_XFER: begin
        w_xfer = 1'b1;
        if (r_cnt == LANE_B3) w_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_base  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we   <= req_we;
        r_base <= req_addr;
        r_cnt  <= LANE_B0;
        r_err  <= w_misaligned;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  word_byte_serdes #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serdes (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_wdata(req_wdata),
    .i_cnt  (r_cnt),
    .i_shift(w_xfer & ~r_we),
    .i_rdata(mem_rdata),
    .o_byte (w_byte),
    .o_word (w_word)
  );

  // DRAM-side outputs are pure decodes of state so an async reset silences them at once.
  assign mem_we     = (r_state == ST_XFER) & r_we;
  assign mem_addr   = (r_state == ST_XFER) ? r_base + ADDR_WIDTH'(r_cnt) : '0;
  assign mem_wdata  = (r_state == ST_XFER) ? w_byte : '0;
  assign resp_rdata = (r_state == ST_RESP) ? w_word : '0;
  assign resp_err   = (r_state == ST_RESP) & r_err;

endmodule

// File: tb/tb_dram_word_master.sv
// tb/tb_dram_word_master.sv - directed bench with a transaction-level model for dram_word_master
module tb_dram_word_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  dram_word_master #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] init_byte(input int i);
    return (i < 4) ? 8'(8'hA0 + i) : 8'h00;
  endfunction

  // Environment DRAM: combinational read, write on the rising edge.
  logic       do_preload;
  logic [7:0] dram [16];
  assign mem_rdata = dram[mem_addr];
  always @(posedge clk) begin
    if (do_preload) for (int i = 0; i < 16; i++) dram[i] <= init_byte(i);
    else if (mem_we) dram[mem_addr] <= mem_wdata;
  end

  logic [3:0] log_a[$];
  logic [7:0] log_d[$];
  int         n_active = 0;
  always @(negedge clk) begin
    if (mem_we) begin
      log_a.push_back(mem_addr);
      log_d.push_back(mem_wdata);
    end
    if (mem_we || mem_addr != 4'h0) n_active++;
  end

  // Model: m_k is the cycle index after acceptance; cycles 1..4 move bytes, later cycles respond.
  bit          m_busy;
  int          m_k;
  logic        m_we;
  logic        m_err;
  logic [3:0]  m_addr;
  logic [31:0] m_wdata;
  logic [7:0]  shadow [16];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      if (do_preload) for (int i = 0; i < 16; i++) shadow[i] <= init_byte(i);
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  <= 1'b1;
        m_k     <= 1;
        m_we    <= req_we;
        m_addr  <= req_addr;
        m_wdata <= req_wdata;
        m_err   <= (req_addr[1:0] != 2'b00);
      end
    end else if (!m_err && m_k <= 4) begin
      if (m_we) shadow[4'(m_addr + m_k - 1)] <= m_wdata[8*(4-m_k) +: 8];
      m_k <= m_k + 1;
    end else if (resp_ready) begin
      m_busy <= 1'b0;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    logic [47:0] e;
    logic [47:0] a;
    logic [3:0]  ea;
    logic [7:0]  eb;
    logic [31:0] ew;
    if (cmp_en) begin
      if (!m_busy) begin
        e = {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0};
      end else if (!m_err && m_k <= 4) begin
        ea = 4'(m_addr + m_k - 1);
        eb = m_wdata[8*(4-m_k) +: 8];
        e  = {1'b0, 1'b0, 1'b0, m_we, ea, eb, 32'h0};
      end else begin
        ew = (m_err || m_we) ? 32'h0 :
             {shadow[m_addr], shadow[4'(m_addr + 1)], shadow[4'(m_addr + 2)], shadow[4'(m_addr + 3)]};
        e  = {1'b0, 1'b1, m_err, 1'b0, 4'h0, 8'h00, ew};
      end
      a = {req_ready, resp_valid, resp_err, mem_we, mem_addr, mem_wdata, resp_rdata};
      chk("cycle_rdy_vld_err_we_addr_wdata_rdata", {16'h0, a}, {16'h0, e});
    end
  end

  task automatic txn(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int lat);
    int n;
    bit got;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_seen", req_ready, 1);
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; got = 1'b0; rdata = '0; err = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) got = 1'b1;
    end
    chk("resp_valid_seen", got, 1);
    rdata = resp_rdata;
    err   = resp_err;
    if (resp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          s;
  int          act0;

  initial begin
    rst = 1'b1; do_preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 do_preload = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_resp_rdata", resp_rdata, 0);
    @(posedge clk);
    #1 rst = 1'b0; cmp_en = 1'b1;

    s = log_a.size();
    txn(1'b1, 4'h4, 32'hDEADBEEF, rd, er, lat);
    chk("wr_byte_count", log_a.size() - s, 4);
    for (int i = 0; i < 4; i++) begin
      chk("wr_addr", log_a[s+i], 4 + i);
    end
    chk("wr_d0", log_d[s+0], 8'hDE);
    chk("wr_d1", log_d[s+1], 8'hAD);
    chk("wr_d2", log_d[s+2], 8'hBE);
    chk("wr_d3", log_d[s+3], 8'hEF);
    chk("wr_err", er, 0);
    chk("wr_latency", lat, 5);

    txn(1'b0, 4'h4, 32'h0, rd, er, lat);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", er, 0);
    chk("rd_latency", lat, 5);

    s = log_a.size(); act0 = n_active;
    txn(1'b0, 4'h6, 32'h0, rd, er, lat);
    chk("mis_err", er, 1);
    chk("mis_rdata", rd, 0);
    chk("mis_latency", lat, 1);
    chk("mis_no_we", log_a.size() - s, 0);
    chk("mis_no_addr", n_active - act0, 0);

    resp_ready = 1'b0;
    txn(1'b0, 4'h4, 32'h0, rd, er, lat);
    chk("bp_first", rd, 32'hDEADBEEF);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h0; req_wdata = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      chk("bp_rdata", resp_rdata, 32'hDEADBEEF);
      chk("bp_err", resp_err, 0);
      chk("bp_req_ready", req_ready, 0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_back_idle", req_ready, 1);

    req_we = 1'b1; req_addr = 4'h8; req_wdata = 32'h11223344; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("rst_no_resp", resp_valid, 0);
    end
    txn(1'b0, 4'h8, 32'h0, rd, er, lat);
    chk("rst_partial_word", rd, 32'h11220000);

    s = log_a.size();
    txn(1'b1, 4'hC, 32'hCAFEF00D, rd, er, lat);
    chk("top_byte_count", log_a.size() - s, 4);
    for (int i = 0; i < 4; i++) begin
      chk("top_addr", log_a[s+i], 12 + i);
    end
    chk("top_no_wrap_addr0", dram[0], 8'hA0);
    txn(1'b0, 4'hC, 32'h0, rd, er, lat);
    chk("top_rd_data", rd, 32'hCAFEF00D);
    chk("top_rd_err", er, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dram_word_master.md
DRAM_WORD_MASTER -- requirements
Module: dram_word_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, DRAM byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, DRAM data width (one byte per access).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1, word request present.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request.
REQ-007 SHALL have port req_we, input, 1, 1 = word write, 0 = word read.
REQ-008 SHALL have port req_addr, input, ADDR_WIDTH, word byte address.
REQ-009 SHALL have port req_wdata, input, 4*DATA_WIDTH, write word.
REQ-010 SHALL have port resp_valid, output, 1, response present.
REQ-011 SHALL have port resp_ready, input, 1, consumer accepts response.
REQ-012 SHALL have port resp_rdata, output, 4*DATA_WIDTH, read word (0 for writes and errors).
REQ-013 SHALL have port resp_err, output, 1, misaligned request flag.
REQ-014 SHALL have ports mem_addr (output, ADDR_WIDTH), mem_wdata (output, DATA_WIDTH), mem_we (output, 1) and mem_rdata (input, DATA_WIDTH); these connect to DRAM addr, wdata, write_enable and rdata.

Function
REQ-015 SHALL implement FSM states IDLE, XFER and RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with req_valid & req_ready, latching req_we, req_addr and req_wdata.
REQ-017 SHALL go IDLE->RESP with resp_err=1 and no DRAM access when req_addr[1:0] != 0.
REQ-018 SHALL otherwise go IDLE->XFER with a 2-bit byte counter cnt=0.
REQ-019 In XFER, SHALL drive mem_addr = base + cnt (mod 2^ADDR_WIDTH), mem_we = latched we, and mem_wdata = word byte cnt, big-endian (cnt 0 -> bits [31:24]).
REQ-020 DRAM read is combinational; on each XFER edge of a read, SHALL shift mem_rdata into the assembly register, so byte cnt 0 lands in bits [31:24].
REQ-021 SHALL increment cnt each XFER cycle, and go XFER->RESP on the edge where cnt==3.
REQ-022 Word latency SHALL be: acceptance edge, then 4 XFER cycles, then resp_valid=1 in the 5th cycle after acceptance.
REQ-023 In RESP, SHALL hold resp_valid, resp_rdata and resp_err stable until resp_valid & resp_ready, then go to IDLE.
REQ-024 mem_we SHALL be 0 in every state except XFER of a write; mem_addr and mem_wdata SHALL be 0 outside XFER.
REQ-025 SHALL ignore req_valid while busy; requests are never queued.
REQ-026 resp_valid and req_ready SHALL never both be 1.

Reset
REQ-027 On rst=1, SHALL immediately (asynchronously) enter IDLE and set req_ready=1 and resp_valid=0.
REQ-028 On rst=1, SHALL set resp_rdata, resp_err, mem_addr, mem_wdata, mem_we, cnt and all latches to 0.
REQ-029 Reset during XFER SHALL abort the word with no response; bytes already written stay in DRAM.

Structure
REQ-030 Package dram_pkg SHALL hold the state encoding (IDLE=0, XFER=1, RESP=2), WORD_BYTES=4 and the byte-lane index constants.
REQ-031 One sub-module, word_byte_serdes, SHALL hold the byte select (write) and shift-assembly (read) datapath; the FSM stays in the top.

Verification
REQ-032 Word write: write addr=0x4, wdata=0xDEADBEEF -> mem_we=1 for 4 cycles, mem_addr 4,5,6,7, mem_wdata DE,AD,BE,EF; then resp_valid with resp_err=0.
REQ-033 Word read: read back addr=0x4 -> resp_rdata=0xDEADBEEF, arriving 5 cycles after acceptance.
REQ-034 Misaligned: read addr=0x6 -> resp_err=1, resp_rdata=0, mem_we never asserted, no mem_addr change.
REQ-035 Backpressure: hold resp_ready=0 for 3 cycles -> response stays stable; a second req_valid during that time is not accepted (req_ready=0).
REQ-036 Reset mid-op: assert rst at the 2nd XFER cycle of a write of 0x11223344 to addr 0x8 -> mem_we=0 at once, no resp_valid, and a read of 0x8 returns 0x1122xxxx (first 2 bytes written).
REQ-037 Top address: write then read addr=0xC on ADDR_WIDTH=4 -> mem_addr 12..15, data matches, no wrap into address 0.
